// File: rtl/register_file_flush.sv
// ---------------------------------------------------------------------------
// register_file_flush
//   Two-read / one-write register file for the decode/writeback datapath:
//   configurable width/depth, optional hard-wired zero register at entry 0,
//   and a sequential flush engine that zeroes one entry per clock with a
//   busy / clr_done handshake. Writes arriving while a flush is running are
//   dropped and flagged on w_err.
//
//   Compile-time option:
//     REGFILE_BYPASS_EN  - when defined, a write in flight is forwarded
//                          combinationally to a read port whose address
//                          matches; when undefined, reads only ever return
//                          stored contents.
// ---------------------------------------------------------------------------
module register_file_flush #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 16,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             n_w,
    input  logic [AW-1:0]    rs,
    input  logic [AW-1:0]    rt,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] data_in,
    input  logic             n_clr,
    output logic [WIDTH-1:0] rs_data_out,
    output logic [WIDTH-1:0] rt_data_out,
    output logic             busy,
    output logic             clr_done,
    output logic             w_err
);

    // IDLE = 0, CLEAR = 1, so busy is simply the state flop itself.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_next;
    logic             r_clr_done;
    logic             w_clr_done_next;
    logic             r_w_err;
    logic             w_w_err_next;

    logic             w_clearing;
    logic             w_flush_last;
    logic             w_wr_en;
    logic [DEPTH-1:0] w_clr_sel;
    logic [DEPTH-1:0] w_wr_sel;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] w_rs_stored;
    logic [WIDTH-1:0] w_rt_stored;

    assign w_clearing   = (r_state == ST_CLEAR);
    assign w_flush_last = (r_ptr == AW'(DEPTH - 1));

    // A write commits only from IDLE; entry 0 is read-only when it is the
    // zero register, and that case is silently ignored rather than flagged.
    assign w_wr_en = !n_w && !w_clearing && !((ZERO_REG != 0) && (rd == '0));

    // ---------------------------------------------------------------------
    // Flush engine
    // ---------------------------------------------------------------------

    // State register: FSM state and flush pointer.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Next-state logic: a request in IDLE starts a sweep from entry 0; the
    // sweep ignores further requests and ends after zeroing entry DEPTH-1.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (!n_clr) begin
                    w_state_next = ST_CLEAR;
                    w_ptr_next   = '0;
                end
            end
            ST_CLEAR: begin
                w_ptr_next = r_ptr + 1'b1;
                if (w_flush_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered status pulses.
    always_comb begin
        w_clr_done_next = 1'b0;
        w_w_err_next    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_done_next = w_flush_last;
                w_w_err_next    = !n_w;
            end
            default: begin
                w_clr_done_next = 1'b0;
                w_w_err_next    = 1'b0;
            end
        endcase
    end

    // Status flops: both pulses last exactly one cycle after their cause.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_clr_done <= 1'b0;
            r_w_err    <= 1'b0;
        end else begin
            r_clr_done <= w_clr_done_next;
            r_w_err    <= w_w_err_next;
        end
    end

    assign busy     = w_clearing;
    assign clr_done = r_clr_done;
    assign w_err    = r_w_err;

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------

    // Per-entry one-hot selects for the flush sweep and for the write port.
    // Both cannot hit in the same cycle since writes are blocked in CLEAR.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign w_clr_sel[gi] = w_clearing && (r_ptr == AW'(gi));
            assign w_wr_sel[gi]  = w_wr_en && (rd == AW'(gi));
        end
    endgenerate

    // Entry array: cleared by reset, by the sweep, or loaded by a write.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_clr_sel[i]) begin
                    r_mem[i] <= '0;
                end else if (w_wr_sel[i]) begin
                    r_mem[i] <= data_in;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------------

    // Stored-value read for both ports, with address 0 forced to zero when
    // it is the zero register.
    always_comb begin
        w_rs_stored = r_mem[rs];
        w_rt_stored = r_mem[rt];
        if ((ZERO_REG != 0) && (rs == '0)) begin
            w_rs_stored = '0;
        end
        if ((ZERO_REG != 0) && (rt == '0)) begin
            w_rt_stored = '0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_rs_byp;
    logic w_rt_byp;

    // Forward a committing write to a matching read port in the same cycle.
    // w_wr_en already excludes busy and the zero register.
    assign w_rs_byp    = w_wr_en && (rs == rd);
    assign w_rt_byp    = w_wr_en && (rt == rd);
    assign rs_data_out = w_rs_byp ? data_in : w_rs_stored;
    assign rt_data_out = w_rt_byp ? data_in : w_rt_stored;
`else
    // No forwarding: new data appears on the ports after the write edge.
    assign rs_data_out = w_rs_stored;
    assign rt_data_out = w_rt_stored;
`endif

endmodule

// File: tb/tb_register_file_flush.sv
// ---------------------------------------------------------------------------
// tb_register_file_flush
//   Drives two instances in lock-step: A = 8-bit x 16 with zero register,
//   B = 16-bit x 32 without. Directed scenarios first, then random traffic,
//   all checked against a time-based reference model of the register file.
// ---------------------------------------------------------------------------
module tb_register_file_flush;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_reset;
    logic        n_w;
    logic        n_clr;

    logic [3:0]  a_rs, a_rt, a_rd;
    logic [7:0]  a_din, a_rs_out, a_rt_out;
    logic        a_busy, a_done, a_werr;

    logic [4:0]  b_rs, b_rt, b_rd;
    logic [15:0] b_din, b_rs_out, b_rt_out;
    logic        b_busy, b_done, b_werr;

    register_file_flush #(.WIDTH(8), .DEPTH(16), .ZERO_REG(1)) u_dut_a (
        .clk         (clk),
        .n_reset     (n_reset),
        .n_w         (n_w),
        .rs          (a_rs),
        .rt          (a_rt),
        .rd          (a_rd),
        .data_in     (a_din),
        .n_clr       (n_clr),
        .rs_data_out (a_rs_out),
        .rt_data_out (a_rt_out),
        .busy        (a_busy),
        .clr_done    (a_done),
        .w_err       (a_werr)
    );

    register_file_flush #(.WIDTH(16), .DEPTH(32), .ZERO_REG(0)) u_dut_b (
        .clk         (clk),
        .n_reset     (n_reset),
        .n_w         (n_w),
        .rs          (b_rs),
        .rt          (b_rt),
        .rd          (b_rd),
        .data_in     (b_din),
        .n_clr       (n_clr),
        .rs_data_out (b_rs_out),
        .rt_data_out (b_rt_out),
        .busy        (b_busy),
        .clr_done    (b_done),
        .w_err       (b_werr)
    );

    // ---------------- reference model ----------------
    // A flush requested at edge k zeroes entry i at edge k+1+i and ends at
    // edge k+DEPTH; busy covers the cycles in between.
    int          depth_of [2] = '{16, 32};
    logic [15:0] mask_of  [2] = '{16'h00FF, 16'hFFFF};
    bit          zreg_of  [2] = '{1'b1, 1'b0};

    logic [15:0] m_mem [2][32];
    int          m_fstart [2];   // edge of the flush request, -1 when idle
    bit          m_done [2];
    bit          m_werr [2];
    int          edge_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic int wr_addr(int j);
        return (j == 0) ? int'(a_rd) : int'(b_rd);
    endfunction

    function automatic logic [15:0] wr_data(int j);
        return ((j == 0) ? {8'h00, a_din} : b_din) & mask_of[j];
    endfunction

    function automatic bit m_busy(int j);
        return m_fstart[j] >= 0;
    endfunction

    function automatic logic [15:0] exp_rd(int j, int addr);
        if (zreg_of[j] && addr == 0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
        if (!n_w && !m_busy(j) && addr == wr_addr(j) && !(zreg_of[j] && wr_addr(j) == 0))
            return wr_data(j);
`endif
        return m_mem[j][addr];
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 32; i++) m_mem[j][i] = 16'h0000;
            m_fstart[j] = -1;
            m_done[j]   = 1'b0;
            m_werr[j]   = 1'b0;
        end
    endtask

    task automatic model_edge(input int j);
        int idx;
        bit dn;
        bit we;
        dn = 1'b0;
        we = 1'b0;
        if (m_busy(j)) begin
            we  = !n_w;
            idx = edge_cnt - m_fstart[j] - 1;
            m_mem[j][idx] = 16'h0000;
            if (idx == depth_of[j] - 1) begin
                m_fstart[j] = -1;
                dn = 1'b1;
            end
        end else begin
            if (!n_w && !(zreg_of[j] && wr_addr(j) == 0))
                m_mem[j][wr_addr(j)] = wr_data(j);
            if (!n_clr) m_fstart[j] = edge_cnt;
        end
        m_done[j] = dn;
        m_werr[j] = we;
    endtask

    task automatic check_outputs(input string ph);
        check_val({ph, " A.busy"},  a_busy,   m_busy(0));
        check_val({ph, " A.done"},  a_done,   m_done[0]);
        check_val({ph, " A.werr"},  a_werr,   m_werr[0]);
        check_val({ph, " A.rs"},    a_rs_out, exp_rd(0, int'(a_rs)));
        check_val({ph, " A.rt"},    a_rt_out, exp_rd(0, int'(a_rt)));
        check_val({ph, " B.busy"},  b_busy,   m_busy(1));
        check_val({ph, " B.done"},  b_done,   m_done[1]);
        check_val({ph, " B.werr"},  b_werr,   m_werr[1]);
        check_val({ph, " B.rs"},    b_rs_out, exp_rd(1, int'(b_rs)));
        check_val({ph, " B.rt"},    b_rt_out, exp_rd(1, int'(b_rt)));
    endtask

    // One cycle: called just after a negedge with inputs already driven.
    task automatic step(input bit do_rst);
        #1;
        check_outputs("pre");
        if (do_rst) begin
            n_reset = 1'b0;
            #1;
            model_reset();
            check_outputs("rst");
            n_reset = 1'b1;
            #1;
        end
        $display("cyc %0d nw=%0b nclr=%0b rst=%0b | A rd=%0d din=%h rs=%0d:%h rt=%0d:%h bsy=%0b | B rd=%0d din=%h rs=%0d:%h rt=%0d:%h bsy=%0b",
                 edge_cnt, n_w, n_clr, do_rst, a_rd, a_din, a_rs, a_rs_out, a_rt, a_rt_out, a_busy,
                 b_rd, b_din, b_rs, b_rs_out, b_rt, b_rt_out, b_busy);
        @(posedge clk);
        edge_cnt++;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic set_ab(input int rd_i, input int rs_i, input int rt_i, input int din_i);
        a_rd  = 4'(rd_i);  a_rs = 4'(rs_i);  a_rt = 4'(rt_i);  a_din = 8'(din_i);
        b_rd  = 5'(rd_i);  b_rs = 5'(rs_i);  b_rt = 5'(rt_i);  b_din = 16'(din_i);
    endtask

    initial begin
        n_reset = 1'b1;
        n_w     = 1'b1;
        n_clr   = 1'b1;
        set_ab(0, 0, 0, 0);
        edge_cnt = 0;
        model_reset();
        #1 n_reset = 1'b0;
        #2 check_outputs("por");
        @(negedge clk);
        n_reset = 1'b1;

        // Reset mid-operation: entry 5 written, then async reset between edges.
        n_w = 1'b0; set_ab(5, 5, 5, 8'hA5); step(1'b0);
        n_w = 1'b1; step(1'b1);

        // Zero register: write 0xFF to address 0, read it back.
        n_w = 1'b0; set_ab(0, 0, 0, 8'hFF); step(1'b0);
        n_w = 1'b1; step(1'b0);
        step(1'b0);

        // Fill every entry with 0x10+i, then flush while watching 7 and 8.
        for (int i = 1; i < 32; i++) begin
            n_w = 1'b0;
            set_ab(i, i, 0, 16'h10 + i);
            a_rd = 4'(i % 16); a_din = 8'(8'h10 + i % 16);
            step(1'b0);
        end
        n_w = 1'b1; set_ab(0, 7, 8, 0);
        n_clr = 1'b0; step(1'b0);
        n_clr = 1'b1;
        for (int c = 0; c < 40; c++) begin
            // A write during the sweep must be dropped and flagged.
            if (c == 4) begin n_w = 1'b0; set_ab(3, 7, 8, 8'h33); end
            else begin n_w = 1'b1; set_ab(0, 7, 8, 0); end
            if (c == 20) set_ab(0, 3, 8, 0);
            step(1'b0);
        end

        // Write and flush request on the same IDLE edge.
        n_w = 1'b0; n_clr = 1'b0; set_ab(2, 2, 1, 8'h22); step(1'b0);
        n_w = 1'b1; n_clr = 1'b1; set_ab(0, 2, 3, 0);
        for (int c = 0; c < 36; c++) step(1'b0);

        // Bypass: old value in 9, then write 0x5C with rd = rs = rt = 9.
        n_w = 1'b0; set_ab(9, 9, 9, 8'h11); step(1'b0);
        n_w = 1'b0; set_ab(9, 9, 9, 8'h5C); step(1'b0);
        n_w = 1'b1; step(1'b0);

        // Random traffic with occasional flushes and async resets.
        for (int c = 0; c < 800; c++) begin
            bit do_rst;
            do_rst = ($urandom_range(0, 99) == 0);
            n_w    = do_rst ? 1'b1 : 1'($urandom_range(0, 1));
            n_clr  = ($urandom_range(0, 24) != 0);
            a_rd   = 4'($urandom_range(0, 15));
            a_rs   = ($urandom_range(0, 3) == 0) ? a_rd : 4'($urandom_range(0, 15));
            a_rt   = 4'($urandom_range(0, 15));
            a_din  = 8'($urandom);
            b_rd   = 5'($urandom_range(0, 31));
            b_rs   = 5'($urandom_range(0, 31));
            b_rt   = ($urandom_range(0, 3) == 0) ? b_rd : 5'($urandom_range(0, 31));
            b_din  = 16'($urandom);
            step(do_rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
